// File: rtl/lb_byte_bridge.sv
// lb_byte_bridge: turns byte-stream command packets (UART/FTDI side) into
// single-cycle LocalBus write/read strobes and streams read data back out.
// Optional burst transfers are compiled in when LB_BRIDGE_BURST_EN is defined.
module lb_byte_bridge #(
  parameter int unsigned rd_timeout     = 255,
  parameter int unsigned rx_gap_timeout = 65535
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic [7:0]  rx_d,
  input  logic        rx_rdy,
  output logic [7:0]  tx_d,
  output logic        tx_rdy,
  input  logic        tx_busy,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        err_pulse
);

  localparam int unsigned CNT_MAX = (rd_timeout > rx_gap_timeout) ? rd_timeout : rx_gap_timeout;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RD_LIM   = CW'(rd_timeout);
  localparam logic [CW-1:0] RD_LAST  = CW'(rd_timeout - 1);
  localparam logic [CW-1:0] GAP_LIM  = CW'(rx_gap_timeout);
  localparam logic [CW-1:0] GAP_LAST = CW'(rx_gap_timeout - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WR, S_RD, S_WAIT, S_TX
  } state_t;

  state_t        state, state_d;
  logic [1:0]    bcnt;      // byte index within the current 4-byte field
  logic [CW-1:0] cnt;       // rx gap counter in ADDR/WDATA, read wait counter in WAIT
  logic          is_rd;
  logic [3:0]    beats;     // transactions still to follow the current one
  logic [31:0]   rdata;     // read data, shifted out MSB first
  logic          tx_gap;    // forces an idle cycle after each tx pulse
  logic          cmd_ok;
  logic [3:0]    cmd_beats;
  logic          more;
  logic          gap_hit;
  logic          rd_hit;

  assign tx_d    = rdata[31:24];
  assign more    = (beats != '0);
  assign gap_hit = (cnt == GAP_LAST);
  assign rd_hit  = (cnt == RD_LAST);

  // Command byte decode: low nibble selects write/read, high nibble is burst length
  always_comb begin
`ifdef LB_BRIDGE_BURST_EN
    cmd_ok    = (rx_d[3:1] == 3'd0);
    cmd_beats = rx_d[7:4];
`else
    cmd_ok    = (rx_d[7:1] == 7'd0);
    cmd_beats = '0;
`endif
  end

  // State register
  always_ff @(posedge clk_lb) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state and strobe outputs
  always_comb begin
    state_d   = state;
    lb_wr     = 1'b0;
    lb_rd     = 1'b0;
    tx_rdy    = 1'b0;
    err_pulse = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_rdy) begin
          if (cmd_ok) state_d = S_ADDR;
          else        err_pulse = 1'b1;
        end
      end
      S_ADDR: begin
        if (rx_rdy) begin
          if (bcnt == 2'd3) state_d = is_rd ? S_RD : S_WDATA;
        end else if (gap_hit) begin
          err_pulse = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_rdy) begin
          if (bcnt == 2'd3) state_d = S_WR;
        end else if (gap_hit) begin
          err_pulse = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WR: begin
        lb_wr   = 1'b1;
        state_d = more ? S_WDATA : S_IDLE;
      end
      S_RD: begin
        lb_rd   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // data arriving on the expiry cycle takes priority over the timeout
        if (lb_rd_rdy) begin
          state_d = S_TX;
        end else if (rd_hit) begin
          err_pulse = 1'b1;
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (!tx_busy && !tx_gap) begin
          tx_rdy = 1'b1;
          if (bcnt == 2'd3) state_d = more ? S_RD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: field shifting, counters, read data capture and burst address stepping
  always_ff @(posedge clk_lb) begin
    if (reset) begin
      bcnt    <= '0;
      cnt     <= '0;
      is_rd   <= 1'b0;
      beats   <= '0;
      rdata   <= '0;
      tx_gap  <= 1'b0;
      lb_addr <= '0;
      lb_wr_d <= '0;
    end else begin
      tx_gap <= tx_rdy;
      case (state)
        S_IDLE: begin
          bcnt <= '0;
          cnt  <= '0;
          if (rx_rdy && cmd_ok) begin
            is_rd <= rx_d[0];
            beats <= cmd_beats;
          end
        end
        S_ADDR: begin
          if (rx_rdy) begin
            lb_addr <= {lb_addr[23:0], rx_d};
            bcnt    <= bcnt + 2'd1;
            cnt     <= '0;
          end else if (cnt != GAP_LIM) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WDATA: begin
          if (rx_rdy) begin
            lb_wr_d <= {lb_wr_d[23:0], rx_d};
            bcnt    <= bcnt + 2'd1;
            cnt     <= '0;
          end else if (cnt != GAP_LIM) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WR: begin
          cnt <= '0;
          if (more) begin
            beats   <= beats - 4'd1;
            lb_addr <= lb_addr + 32'd4;
          end
        end
        S_RD: begin
          cnt <= '0;
        end
        S_WAIT: begin
          if (lb_rd_rdy)           rdata <= lb_rd_d;
          else if (rd_hit)         rdata <= 32'hDEADBEEF;
          else if (cnt != RD_LIM)  cnt   <= cnt + CW'(1);
        end
        S_TX: begin
          if (tx_rdy) begin
            rdata <= {rdata[23:0], 8'h00};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3 && more) begin
              beats   <= beats - 4'd1;
              lb_addr <= lb_addr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_byte_bridge.sv
// Bench for lb_byte_bridge: table of single transactions plus hand-written
// sequences for bad commands, rx gap timeout, reset mid-read and bursts.
`timescale 1ns/1ps
module tb_lb_byte_bridge;

  localparam int unsigned RD_TMO  = 8;
  localparam int unsigned GAP_TMO = 32;

  logic        clk_lb = 1'b0;
  logic        reset;
  logic [7:0]  rx_d;
  logic        rx_rdy;
  logic [7:0]  tx_d;
  logic        tx_rdy;
  logic        tx_busy;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic        err_pulse;

  always #5 clk_lb = ~clk_lb;

  lb_byte_bridge #(.rd_timeout(RD_TMO), .rx_gap_timeout(GAP_TMO)) dut (
    .clk_lb(clk_lb), .reset(reset), .rx_d(rx_d), .rx_rdy(rx_rdy),
    .tx_d(tx_d), .tx_rdy(tx_rdy), .tx_busy(tx_busy),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .err_pulse(err_pulse)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int unsigned delay; logic [31:0] data; } resp_t;
  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned rdelay;    // cycles from lb_rd to lb_rd_rdy, 0 = never answer
    logic [31:0] rdata;
    int unsigned busy_len;  // tx_busy cycles raised after each tx pulse
    logic [31:0] exp_tx;
    bit          exp_err;
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  resp_t       resp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;
  int unsigned last_rx = 0, wr_cyc = 0, rd_cyc = 0, err_cyc = 0, last_tx_cyc = 0;
  int unsigned wr_count = 0, rd_count = 0, tx_count = 0, err_count = 0;
  int unsigned pend = 0, busy_left = 0, busy_len = 0;
  logic [31:0] pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: observe DUT at the falling edge, then update responder and
  // transmitter models just after the next rising edge.
  task automatic tick();
    wr_t   e;
    resp_t r;
    logic [7:0] b;
    @(negedge clk_lb);
    if (lb_wr) begin
      wr_count++;
      wr_cyc = cyc;
      if (wr_q.size() == 0) check("unexpected_lb_wr", 32'(lb_wr), 32'd0);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", lb_addr, e.addr);
        check("wr_data", lb_wr_d, e.data);
      end
    end
    if (lb_rd) begin
      rd_count++;
      rd_cyc = cyc;
      if (rd_q.size() == 0) check("unexpected_lb_rd", 32'(lb_rd), 32'd0);
      else check("rd_addr", lb_addr, rd_q.pop_front());
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        pend = r.delay;
        pend_data = r.data;
      end else pend = 0;
    end
    if (tx_rdy) begin
      check("tx_while_busy", 32'(tx_busy), 32'd0);
      if (tx_count > 0) check("tx_spacing_ok", 32'(cyc - last_tx_cyc >= 2), 32'd1);
      if (tx_q.size() == 0) check("unexpected_tx_rdy", 32'(tx_rdy), 32'd0);
      else begin
        b = tx_q.pop_front();
        check("tx_byte", 32'(tx_d), 32'(b));
      end
      tx_count++;
      last_tx_cyc = cyc;
      busy_left = busy_len;
    end
    if (err_pulse) begin
      err_count++;
      err_cyc = cyc;
    end
    @(posedge clk_lb);
    #1;
    cyc++;
    if (pend > 0) begin
      pend--;
      lb_rd_rdy = (pend == 0);
    end else lb_rd_rdy = 1'b0;
    lb_rd_d = lb_rd_rdy ? pend_data : $urandom();
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else tx_busy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_d = b;
    rx_rdy = 1'b1;
    last_rx = cyc;
    tick();
    rx_rdy = 1'b0;
    rx_d = 8'($urandom());
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic wait_drain(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while ((wr_q.size() + rd_q.size() + tx_q.size()) != 0 && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(wr_q.size() + rd_q.size() + tx_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_d"}, 32'(tx_d), 32'd0);
    check({tag, "_tx_rdy"}, 32'(tx_rdy), 32'd0);
    check({tag, "_lb_wr"}, 32'(lb_wr), 32'd0);
    check({tag, "_lb_rd"}, 32'(lb_rd), 32'd0);
    check({tag, "_lb_addr"}, lb_addr, 32'd0);
    check({tag, "_lb_wr_d"}, lb_wr_d, 32'd0);
    check({tag, "_err"}, 32'(err_pulse), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned e0, t0, lastbyte;
    wr_t w;
    resp_t r;
    e0 = err_count;
    t0 = tx_count;
    busy_len = v.busy_len;
    if (v.cmd[0]) begin
      rd_q.push_back(v.addr);
      r.delay = v.rdelay;
      r.data = v.rdata;
      resp_q.push_back(r);
      for (int i = 3; i >= 0; i--) tx_q.push_back(v.exp_tx[8*i +: 8]);
    end else begin
      w.addr = v.addr;
      w.data = v.wdata;
      wr_q.push_back(w);
    end
    send_byte(v.cmd);
    send_word(v.addr);
    lastbyte = last_rx;
    if (!v.cmd[0]) begin
      send_word(v.wdata);
      lastbyte = last_rx;
    end
    wait_drain(tag, 300);
    if (v.cmd[0]) begin
      check({tag, "_rd_latency"}, rd_cyc - lastbyte, 32'd1);
      if (v.exp_err) check({tag, "_tmo_latency"}, err_cyc - rd_cyc, RD_TMO);
    end else begin
      check({tag, "_wr_latency"}, wr_cyc - lastbyte, 32'd1);
      check({tag, "_no_tx"}, tx_count - t0, 32'd0);
    end
    check({tag, "_err_count"}, err_count - e0, 32'(v.exp_err));
  endtask

  vec_t tbl[6];

  initial begin
    int unsigned e0, r0, t0, w0, n, d, c0;
    logic [7:0] bad[$];
    resp_t r;
    wr_t w;

    tbl[0] = '{cmd: 8'h00, addr: 32'h0000_0010, wdata: 32'h0000_0001, rdelay: 0, rdata: 32'h0, busy_len: 0, exp_tx: 32'h0, exp_err: 1'b0};
    tbl[1] = '{cmd: 8'h01, addr: 32'h0000_0000, wdata: 32'h0, rdelay: 3, rdata: 32'h1122_3344, busy_len: 3, exp_tx: 32'h1122_3344, exp_err: 1'b0};
    tbl[2] = '{cmd: 8'h01, addr: 32'h0000_00F0, wdata: 32'h0, rdelay: 0, rdata: 32'h0, busy_len: 2, exp_tx: 32'hDEAD_BEEF, exp_err: 1'b1};
    tbl[3] = '{cmd: 8'h01, addr: 32'h0000_0004, wdata: 32'h0, rdelay: RD_TMO, rdata: 32'hCAFE_F00D, busy_len: 0, exp_tx: 32'hCAFE_F00D, exp_err: 1'b0};
    tbl[4] = '{cmd: 8'h00, addr: 32'hFFFF_FFF0, wdata: 32'hA5A5_5A5A, rdelay: 0, rdata: 32'h0, busy_len: 0, exp_tx: 32'h0, exp_err: 1'b0};
    tbl[5] = '{cmd: 8'h01, addr: 32'h1234_5678, wdata: 32'h0, rdelay: 1, rdata: 32'h0BAD_F00D, busy_len: 5, exp_tx: 32'h0BAD_F00D, exp_err: 1'b0};

    reset = 1'b1; rx_d = '0; rx_rdy = 1'b0; tx_busy = 1'b0; lb_rd_rdy = 1'b0; lb_rd_d = '0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Undecodable command bytes are dropped with an error pulse
    bad = '{8'h07, 8'h02, 8'hFF};
`ifndef LB_BRIDGE_BURST_EN
    bad.push_back(8'h11);
    bad.push_back(8'h30);
`endif
    foreach (bad[k]) begin
      e0 = err_count; w0 = wr_count; r0 = rd_count;
      send_byte(bad[k]);
      repeat (2) tick();
      check($sformatf("bad_cmd_%h_err", bad[k]), err_count - e0, 32'd1);
      check($sformatf("bad_cmd_%h_nostrobe", bad[k]), (wr_count - w0) + (rd_count - r0), 32'd0);
    end

    // Truncated read followed by rx silence resynchronises to idle
    e0 = err_count; r0 = rd_count;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    n = 0;
    while (err_count == e0 && n < GAP_TMO + 10) begin tick(); n++; end
    d = err_cyc - last_rx;
    check("gap_err_count", err_count - e0, 32'd1);
    check("gap_err_latency_ok", 32'(d >= GAP_TMO && d <= GAP_TMO + 2), 32'd1);
    repeat (4) tick();
    check("gap_no_rd", rd_count - r0, 32'd0);
    run_vec('{cmd: 8'h01, addr: 32'h0000_0004, wdata: 32'h0, rdelay: 2, rdata: 32'h7766_5544,
              busy_len: 1, exp_tx: 32'h7766_5544, exp_err: 1'b0}, "after_gap");

    // Reset pulse while waiting for read data; the late lb_rd_rdy must be ignored
    rd_q.push_back(32'h0000_0040);
    r.delay = 6; r.data = 32'h55AA_55AA;
    resp_q.push_back(r);
    busy_len = 0;
    c0 = rd_count;
    send_byte(8'h01);
    send_word(32'h0000_0040);
    n = 0;
    while (rd_count == c0 && n < 20) begin tick(); n++; end
    check("rst_rd_seen", rd_count - c0, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rst_wait");
    e0 = err_count; t0 = tx_count; w0 = wr_count; r0 = rd_count;
    repeat (20) tick();
    check("rst_no_tx", tx_count - t0, 32'd0);
    check("rst_no_err", err_count - e0, 32'd0);
    check("rst_no_strobe", (wr_count - w0) + (rd_count - r0), 32'd0);
    run_vec('{cmd: 8'h01, addr: 32'h0000_0044, wdata: 32'h0, rdelay: 4, rdata: 32'h0102_0304,
              busy_len: 2, exp_tx: 32'h0102_0304, exp_err: 1'b0}, "after_rst");

`ifdef LB_BRIDGE_BURST_EN
    // Three-beat read wrapping past the top of the address space, middle beat times out
    e0 = err_count;
    rd_q.push_back(32'hFFFF_FFFC); rd_q.push_back(32'h0000_0000); rd_q.push_back(32'h0000_0004);
    r.delay = 2; r.data = 32'hA1A2_A3A4; resp_q.push_back(r);
    r.delay = 0; r.data = 32'h0;         resp_q.push_back(r);
    r.delay = 3; r.data = 32'hC1C2_C3C4; resp_q.push_back(r);
    tx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    busy_len = 1;
    send_byte(8'h21);
    send_word(32'hFFFF_FFFC);
    wait_drain("burst_rd", 600);
    check("burst_rd_err", err_count - e0, 32'd1);

    // Two-beat write; second dword is sent once the first strobe has gone out
    w.addr = 32'h0000_0100; w.data = 32'h1111_1111; wr_q.push_back(w);
    w.addr = 32'h0000_0104; w.data = 32'h2222_2222; wr_q.push_back(w);
    w0 = wr_count;
    send_byte(8'h10);
    send_word(32'h0000_0100);
    send_word(32'h1111_1111);
    tick();
    send_word(32'h2222_2222);
    wait_drain("burst_wr", 50);
    check("burst_wr_count", wr_count - w0, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
